// File: rtl/aes_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES definitions: round-count constants, key_len
//                encoding, FSM state encoding and the GF(2^8) byte and block
//                primitives used by the round datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    localparam logic [1:0] KEY_LEN_BAD = 2'b00;
    localparam logic [1:0] KEY_LEN_128 = 2'b01;
    localparam logic [1:0] KEY_LEN_192 = 2'b10;
    localparam logic [1:0] KEY_LEN_256 = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_INIT  = 2'd1;
    localparam state_t ST_ROUND = 2'd2;
    localparam state_t ST_HOLD  = 2'd3;

    // Unsupported encoding 00 falls back to the AES-128 round count.
    function automatic logic [3:0] nr_of(input logic [1:0] key_len);
        case (key_len)
            KEY_LEN_192: return NR_192;
            KEY_LEN_256: return NR_256;
            default:     return NR_128;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    // Byte i of a block sits at [127-8i -: 8]; state element (row r, col c) is byte 4c+r.
    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv ? inv_sbox(s[127-8*i -: 8]) : sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        int src;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input bit inv);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            if (inv) begin
                o[127-32*c -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
                o[119-32*c -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
                o[111-32*c -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
                o[103-32*c -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
            end else begin
                o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end
        end
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_datapath.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : aes_round_datapath
//  Description : Combinational AES round. Encrypt: SubBytes, ShiftRows,
//                MixColumns (skipped on the last round), AddRoundKey.
//                Decrypt: InvShiftRows, InvSubBytes, AddRoundKey,
//                InvMixColumns (skipped on the last round).
//  Ports       : i_state, i_subkey (128) - round input and round key
//                i_dec, i_last          - direction and final-round flag
//                o_next_state (128)     - round result
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_round_datapath
    import aes_pkg::*;
#(
    parameter bit ENABLE_DECRYPT = 1'b1
) (
    input  logic [127:0] i_state,
    input  logic [127:0] i_subkey,
    input  logic         i_dec,
    input  logic         i_last,
    output logic [127:0] o_next_state
);

    logic [127:0] w_enc_sr;
    logic [127:0] w_enc_out;

    assign w_enc_sr  = shift_rows(sub_bytes(i_state, 1'b0), 1'b0);
    assign w_enc_out = (i_last ? w_enc_sr : mix_columns(w_enc_sr, 1'b0)) ^ i_subkey;

    generate
        if (ENABLE_DECRYPT) begin : g_dec
            logic [127:0] w_dec_ark;
            logic [127:0] w_dec_out;
            assign w_dec_ark    = sub_bytes(shift_rows(i_state, 1'b1), 1'b1) ^ i_subkey;
            assign w_dec_out    = i_last ? w_dec_ark : mix_columns(w_dec_ark, 1'b1);
            assign o_next_state = i_dec ? w_dec_out : w_enc_out;
        end else begin : g_enc_only
            logic w_unused;
            assign w_unused     = i_dec;
            assign o_next_state = w_enc_out;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/aes_cipher_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : aes_cipher_core
//  Description : Iterative AES-128/192/256 encrypt/decrypt engine. One round
//                per accepted round key; keys are fetched one at a time from
//                the key-expansion RAM. One-deep output buffer lets a new
//                block start while the previous result waits downstream.
//  Ports       : clk, reset_n                 - clock, async active-low reset
//                in_valid/in_ready/in_block   - input block handshake
//                key_len, mode_dec            - sampled on accept
//                subkey_addr/subkey/subkey_valid - round-key fetch
//                out_valid/out_ready/out_block   - output buffer handshake
//                busy, err                    - status, bad key_len pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_cipher_core
    import aes_pkg::*;
#(
    parameter int unsigned SKEY_AW        = 4,
    parameter bit          ENABLE_DECRYPT = 1'b1,
    parameter bit          ERR_ON_BAD_LEN = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       in_block,
    input  logic [1:0]         key_len,
    input  logic               mode_dec,
    output logic [SKEY_AW-1:0] subkey_addr,
    input  logic [127:0]       subkey,
    input  logic               subkey_valid,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out_block,
    output logic               busy,
    output logic               err
);

    state_t             r_fsm;
    logic [127:0]       r_state;
    logic [3:0]         r_round;
    logic [3:0]         r_nr;
    logic               r_dec;
    logic [SKEY_AW-1:0] r_addr;
    logic               r_out_valid;
    logic [127:0]       r_out_block;
    logic               r_err;

    logic               w_mode;
    logic               w_bad_len;
    logic [3:0]         w_nr;
    logic               w_last;
    logic               w_buf_free;
    logic [SKEY_AW-1:0] w_addr_next;
    logic [127:0]       w_round_out;

    assign w_mode      = ENABLE_DECRYPT && mode_dec;
    assign w_bad_len   = ERR_ON_BAD_LEN && (key_len == KEY_LEN_BAD);
    assign w_nr        = nr_of(key_len);
    assign w_last      = (r_round == r_nr);
    // Buffer can take a result if empty or being drained on this same edge.
    assign w_buf_free  = !r_out_valid || out_ready;
    assign w_addr_next = r_dec ? r_addr - SKEY_AW'(1) : r_addr + SKEY_AW'(1);

    aes_round_datapath #(
        .ENABLE_DECRYPT (ENABLE_DECRYPT)
    ) u_round (
        .i_state      (r_state),
        .i_subkey     (subkey),
        .i_dec        (r_dec),
        .i_last       (w_last),
        .o_next_state (w_round_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fsm       <= ST_IDLE;
            r_state     <= '0;
            r_round     <= '0;
            r_nr        <= NR_128;
            r_dec       <= 1'b0;
            r_addr      <= '0;
            r_out_valid <= 1'b0;
            r_out_block <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            // Drain first; a reload below on the same edge overrides this.
            if (r_out_valid && out_ready) r_out_valid <= 1'b0;

            case (r_fsm)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (w_bad_len) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state <= in_block;
                            r_nr    <= w_nr;
                            r_dec   <= w_mode;
                            r_round <= '0;
                            r_addr  <= w_mode ? SKEY_AW'(w_nr) : '0;
                            r_fsm   <= ST_INIT;
                        end
                    end
                end
                ST_INIT: begin
                    if (subkey_valid) begin
                        r_state <= r_state ^ subkey;
                        r_round <= 4'd1;
                        r_addr  <= w_addr_next;
                        r_fsm   <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    if (subkey_valid) begin
                        if (w_last) begin
                            if (w_buf_free) begin
                                r_out_block <= w_round_out;
                                r_out_valid <= 1'b1;
                                r_fsm       <= ST_IDLE;
                            end else begin
                                r_state <= w_round_out;
                                r_fsm   <= ST_HOLD;
                            end
                        end else begin
                            r_state <= w_round_out;
                            r_round <= r_round + 4'd1;
                            r_addr  <= w_addr_next;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_buf_free) begin
                        r_out_block <= r_state;
                        r_out_valid <= 1'b1;
                        r_fsm       <= ST_IDLE;
                    end
                end
                default: r_fsm <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_fsm == ST_IDLE);
    assign busy        = (r_fsm != ST_IDLE);
    assign subkey_addr = r_addr;
    assign out_valid   = r_out_valid;
    assign out_block   = r_out_block;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_cipher_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_aes_cipher_core
//  Description : Self-checking bench for aes_cipher_core. Round keys come from
//                an independent key expansion; results are checked against
//                FIPS-197 vectors through an in-order scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_cipher_core;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] K128   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192   = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    localparam logic [2047:0] SBOX_ROWS = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_block = '0;
    logic [1:0]   key_len = 2'b01;
    logic         mode_dec = 1'b0;
    logic [3:0]   subkey_addr;
    logic [127:0] subkey;
    logic         subkey_valid = 1'b1;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_block;
    logic         busy;
    logic         err;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [127:0] exp_q [$];
    logic [3:0]   addr_log [$];
    logic [127:0] rks [15];
    logic [7:0]   sbox_t [256];
    bit           gap_en = 1'b0;

    typedef struct {
        logic [1:0]   kl;
        logic         dec;
        logic [255:0] key;
        logic [127:0] din;
        logic [127:0] dout;
        int           lat;
        logic [3:0]   a_first;
        logic [3:0]   a_last;
    } vec_t;
    vec_t vecs [5];

    aes_cipher_core #(
        .SKEY_AW        (4),
        .ENABLE_DECRYPT (1'b1),
        .ERR_ON_BAD_LEN (1'b1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_block     (in_block),
        .key_len      (key_len),
        .mode_dec     (mode_dec),
        .subkey_addr  (subkey_addr),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_block    (out_block),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Key RAM model: data follows the address combinationally, validity is
    // either always-on or randomly gapped (about 30% low).
    assign subkey = rks[subkey_addr];
    always @(posedge clk) begin
        #1 subkey_valid = gap_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Monitor: scoreboard pop on transfer, out_block stability under
    // backpressure, address hold while subkey_valid is low, address trace.
    logic         prev_stall = 1'b0;
    logic [127:0] prev_blk   = '0;
    logic         prev_busy  = 1'b0;
    logic         prev_sv    = 1'b1;
    logic [3:0]   prev_addr  = '0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (prev_stall) check("out_block_stable", out_block, prev_blk);
            if (prev_busy && busy && !prev_sv) check("addr_hold_gap", {124'h0, subkey_addr}, {124'h0, prev_addr});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h expected none", out_block);
                end else begin
                    check("scoreboard", out_block, exp_q.pop_front());
                end
            end
            if (busy && (addr_log.size() == 0 || addr_log[$] != subkey_addr))
                addr_log.push_back(subkey_addr);
        end
        prev_stall = reset_n && out_valid && !out_ready;
        prev_blk   = out_block;
        prev_busy  = reset_n && busy;
        prev_sv    = subkey_valid;
        prev_addr  = subkey_addr;
    end

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input logic [1:0] kl);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk;
        int nr;
        nk = (kl == 2'b11) ? 8 : (kl == 2'b10) ? 6 : 4;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int j = 0; j < 15; j++) rks[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send(input logic [1:0] kl, input logic dec, input logic [127:0] blk,
                        input logic [127:0] exp, input bit expect_out);
        int t;
        in_valid = 1'b1;
        key_len  = kl;
        mode_dec = dec;
        in_block = blk;
        t = 0;
        while (!in_ready && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
            return;
        end
        addr_log.delete();
        @(posedge clk);
        if (expect_out) exp_q.push_back(exp);
        #1 in_valid = 1'b0;
    endtask

    // Latency counts from the handshake cycle to the first cycle with out_valid.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) fail_now("out_valid_timeout");
    endtask

    task automatic run_vec(input vec_t v, input bit chk_lat);
        int lat;
        expand(v.key, v.kl);
        send(v.kl, v.dec, v.din, v.dout, 1'b1);
        wait_out(lat);
        if (chk_lat) check("latency", lat, v.lat);
        repeat (2) @(posedge clk);
        #1;
        check("addr_count", addr_log.size(), v.lat - 1);
        if (addr_log.size() > 0) begin
            check("addr_first", {124'h0, addr_log[0]}, {124'h0, v.a_first});
            check("addr_last",  {124'h0, addr_log[$]}, {124'h0, v.a_last});
        end
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 256; i++) sbox_t[i] = SBOX_ROWS[2047-8*i -: 8];
        vecs[0] = '{2'b01, 1'b0, K128, PT,    CT128, 12, 4'd0,  4'd10};
        vecs[1] = '{2'b10, 1'b0, K192, PT,    CT192, 14, 4'd0,  4'd12};
        vecs[2] = '{2'b11, 1'b0, K256, PT,    CT256, 16, 4'd0,  4'd14};
        vecs[3] = '{2'b11, 1'b1, K256, CT256, PT,    16, 4'd14, 4'd0};
        vecs[4] = '{2'b01, 1'b1, K128, CT128, PT,    12, 4'd10, 4'd0};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_block", out_block, 0);
        check("rst_busy",      busy,      0);
        check("rst_err",       err,       0);
        check("rst_addr",      subkey_addr, 0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // Gap-free vectors
        for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b1);

        // Random subkey_valid gaps: same results, address held during gaps
        gap_en = 1'b1;
        run_vec(vecs[0], 1'b0);
        run_vec(vecs[2], 1'b0);
        run_vec(vecs[3], 1'b0);
        gap_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Bad key_len: dropped with one-cycle err pulse
        send(2'b00, 1'b0, PT, '0, 1'b0);
        check("bad_err_pulse", err, 1);
        check("bad_not_busy",  busy, 0);
        check("bad_in_ready",  in_ready, 1);
        @(posedge clk); #1;
        check("bad_err_clear", err, 0);
        repeat (20) @(posedge clk);
        #1;
        check("bad_no_output", out_valid, 0);

        // Backpressure: two blocks, second completes into HOLD
        expand(K128, 2'b01);
        out_ready = 1'b0;
        send(2'b01, 1'b0, PT, CT128, 1'b1);
        wait_out(lat);
        check("bp_latency", lat, 12);
        check("bp_ready_after_done", in_ready, 1);
        send(2'b01, 1'b1, CT128, PT, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check("bp_hold_busy",     busy,      1);
        check("bp_hold_in_ready", in_ready,  0);
        check("bp_hold_valid",    out_valid, 1);
        check("bp_hold_block",    out_block, CT128);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_second_valid", out_valid, 1);
        check("bp_second_block", out_block, PT);
        check("bp_second_idle",  busy,      0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_drained", out_valid, 0);

        // Reset in the middle of round 5 aborts the block
        send(2'b01, 1'b0, PT, CT128, 1'b1);
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_in_ready",  in_ready,  1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_block", out_block, 0);
        check("mid_rst_busy",      busy,      0);
        check("mid_rst_err",       err,       0);
        check("mid_rst_addr",      subkey_addr, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        run_vec(vecs[0], 1'b1);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/aes_cipher_core.md
Name: aes_cipher_core

Overview:
- Parametrised successor to the iterative AES encrypt engine: one iterative round datapath serving both encryption and decryption, for AES-128, AES-192 and AES-256.
- Sits between the block-mode controller (upstream) and the output formatter (downstream). Uses valid/ready handshakes on both sides.
- Fetches round keys one at a time from the key-expansion RAM over an addr/valid interface with variable latency.
- Adds a one-deep output buffer, so a new block can be accepted while the previous result waits for the consumer.

Parameters:
- SKEY_AW, 4, width of subkey_addr; must be ≥4 (14 is the highest round-key index).
- ENABLE_DECRYPT, 1, 0 = encrypt-only build (mode_dec ignored and treated as 0; inverse datapath not instantiated).
- ERR_ON_BAD_LEN, 1, 1 = key_len 2'b00 is rejected with an err pulse; 0 = it is treated as AES-128.

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input block offered
- in_ready  out  1  core can accept a block
- in_block  in  128  plaintext (encrypt) or ciphertext (decrypt)
- key_len  in  2  01=AES-128 (Nr=10), 10=AES-192 (Nr=12), 11=AES-256 (Nr=14); sampled on accept
- mode_dec  in  1  0=encrypt, 1=decrypt; sampled on accept
- subkey_addr  out  SKEY_AW  round-key index requested
- subkey  in  128  round key for subkey_addr
- subkey_valid  in  1  subkey is valid for the current subkey_addr
- out_valid  out  1  result in the output buffer
- out_ready  in  1  consumer takes the result
- out_block  out  128  result block
- busy  out  1  engine is not IDLE
- err  out  1  one-cycle pulse when a bad key_len is rejected

Behaviour:
- Reset (async assert, sync deassert) values: state=IDLE, in_ready=1, out_valid=0, out_block=0, busy=0, err=0, subkey_addr=0, round counter=0, state register=0.
  - Reset mid-block aborts the block; no partial output is produced.
- Accept: a block is accepted on an edge where in_valid && in_ready.
  - The core latches in_block, Nr and mode, then moves to INIT.
  - in_ready = (state==IDLE). While the engine is busy, in_valid is ignored.
- Bad key_len: key_len==00 with ERR_ON_BAD_LEN=1 at an accept edge → block dropped, err=1 for exactly one cycle, state stays IDLE.
- subkey_addr:
  - Encrypt requests keys 0,1,…,Nr.
  - Decrypt requests keys Nr,Nr-1,…,0.
  - The address is driven from a register and held until subkey_valid is seen; the core never advances without subkey_valid.
- INIT: on subkey_valid, state ← in_block ^ subkey, the address steps, state goes to ROUND, and round counter r ← 1.
- ROUND, encrypt: state ← AddRoundKey(MixColumns(ShiftRows(SubBytes(state)))), with MixColumns bypassed when r==Nr.
- ROUND, decrypt: state ← InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)))), with InvMixColumns bypassed when r==Nr.
- Round step: each round advances only on subkey_valid; r increments.
- Final round (r==Nr with subkey_valid):
  - If the output buffer is empty, or is being drained that same cycle (out_valid && out_ready): out_block ← round result, out_valid=1, state goes to IDLE.
  - Otherwise the result is held in the state register and the FSM goes to HOLD. It leaves HOLD to IDLE on the first cycle the buffer is free, loading out_block.
- Latency: with subkey_valid tied to 1, out_valid rises Nr+2 clocks after the accept edge (12 for AES-128, 14 for AES-192, 16 for AES-256). Throughput is one block per Nr+2 cycles.
- Output buffer:
  - out_valid && out_ready clears out_valid, unless the buffer is reloaded in the same edge; a reload takes priority and out_valid stays 1.
  - out_block is stable while out_valid && !out_ready.
- A subkey_valid stall of any length in any state only delays completion; the result is unchanged.
- busy = (state != IDLE).
- Widths: the round counter is 4 bits; all datapath operations are pure GF(2^8) and byte permutations, with no carries.

Decomposition:
- Shared package aes_pkg holds:
  - NR_128/NR_192/NR_256 constants (10/12/14)
  - key_len encoding constants
  - the FSM state typedef: IDLE, INIT, ROUND, HOLD
  - the helper function nr_of(key_len)
- One sub-module, aes_round_datapath (combinational): inputs state, subkey, dec, last; output next_state. It instantiates the team's existing SubBytes/ShiftRows/MixColumns/AddRoundKey primitives and their inverse counterparts. When ENABLE_DECRYPT=0 the inverse path is generate-disabled.
- The FSM, counters, address register and output buffer live in aes_cipher_core.

Test Plan:
- AES-128 encrypt, key 000102…0f, pt 00112233445566778899aabbccddeeff, subkey_valid=1 → out_block 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 12 cycles after accept, subkey_addr sequence 0..10.
- AES-192/AES-256 encrypt, keys 00..17 / 00..1f, same pt → dda97ca4864cdfe06eaf70a0ec0d7191 / 8ea2b7ca516745bfeafc49904b496089; latency 14 / 16.
- AES-256 decrypt of 8ea2b7ca516745bfeafc49904b496089 → 00112233445566778899aabbccddeeff; subkey_addr sequence 14..0.
- Backpressure: hold out_ready=0 and issue two AES-128 blocks back-to-back →
  - the second block accepts right after the first completes, then enters HOLD;
  - out_block stays stable;
  - raising out_ready for one cycle delivers block 1, then block 2 one cycle later with out_valid continuous.
- Random subkey_valid gaps (30% low) → identical ciphertext to the gap-free case; subkey_addr holds during gaps; key_len=00 → err pulse for 1 cycle, no out_valid.
- Assert reset_n low mid-round (r=5) → all outputs at reset values asynchronously; after release, a fresh AES-128 block completes correctly.
